// File: rtl/keyboard_pkg.sv
// keyboard_pkg: shared keyboard geometry, highlight FSM states and colour helpers
package keyboard_pkg;
  localparam logic [9:0] KEY_TOP    = 10'd360;
  localparam logic [9:0] WHITE_W    = 10'd23;
  localparam logic [9:0] BLACK_W    = 10'd12;
  localparam logic [9:0] WHITE_H    = 10'd120;
  localparam logic [9:0] BLACK_H    = 10'd80;
  localparam logic [9:0] NO_KEY_POS = 10'd640;
  typedef enum logic [1:0] {IDLE, ACTIVE, FADE} hl_state_t;
  localparam logic [11:0] COLOR_WHITE = 12'h0F0;
  localparam logic [11:0] COLOR_BLACK = 12'hF00;
  // masks the key colour with the intensity replicated into every channel
  function automatic logic [11:0] shade(input logic blk, input logic [3:0] i);
    return (blk ? COLOR_BLACK : COLOR_WHITE) & {3{i}};
  endfunction
endpackage

// File: rtl/key_highlight_if.sv
// key_highlight_if: key/scan inputs (master drives) and highlight pixel outputs (slave drives)
interface key_highlight_if;
  logic        note_on;
  logic [9:0]  position;
  logic        black;
  logic        frame_start;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        valid;
  logic        hit;
  logic [11:0] rgb;
  logic        pixel_valid;
  modport master (output note_on, position, black, frame_start, h_cnt, v_cnt, valid,
                  input hit, rgb, pixel_valid);
  modport slave  (input note_on, position, black, frame_start, h_cnt, v_cnt, valid,
                  output hit, rgb, pixel_valid);
endinterface

// File: rtl/highlight_fade_fsm.sv
// highlight_fade_fsm: per-frame key latch and IDLE/ACTIVE/FADE state; outputs active, cur_pos, cur_black, intensity
module highlight_fade_fsm import keyboard_pkg::*; #(
  parameter int unsigned HOLD_FRAMES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       note_on,
  input  logic [9:0] position,
  input  logic       black,
  output logic       active,
  output logic [9:0] cur_pos,
  output logic       cur_black,
  output logic [3:0] intensity
);
  hl_state_t  state;
  logic [3:0] hold_cnt;
  logic       press;
  assign press     = note_on && position != NO_KEY_POS;
  assign active    = state != IDLE;
  // hold_cnt is zero outside FADE, so it doubles as the fade/idle intensity
  assign intensity = state == ACTIVE ? 4'hF : hold_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      cur_pos   <= '0;
      cur_black <= 1'b0;
    end else if (frame_start) begin
      if (press) begin
        state     <= ACTIVE;
        hold_cnt  <= '0;
        cur_pos   <= position;
        cur_black <= black;
      end else if (state == ACTIVE) begin
        state    <= FADE;
        hold_cnt <= 4'(HOLD_FRAMES);
      end else if (state == FADE) begin
        hold_cnt <= hold_cnt - 4'd1;
        if (hold_cnt <= 4'd1) state <= IDLE;
      end
    end
endmodule

// File: rtl/key_highlight.sv
// key_highlight: paints a fading highlight rectangle over the pressed key; clk/rst plus bus (slave) carrying key, scan and pixel signals
module key_highlight import keyboard_pkg::*; #(
  parameter int unsigned HOLD_FRAMES = 15
) (
  input logic           clk,
  input logic           rst,
  key_highlight_if.slave bus
);
  logic        active, cur_black, hit_c;
  logic [9:0]  cur_pos;
  logic [3:0]  intensity;
  logic [10:0] hx, vy, px, w, ht, top;
  highlight_fade_fsm #(.HOLD_FRAMES(HOLD_FRAMES)) fsm (
    .clk(clk), .rst(rst), .frame_start(bus.frame_start), .note_on(bus.note_on),
    .position(bus.position), .black(bus.black), .active(active),
    .cur_pos(cur_pos), .cur_black(cur_black), .intensity(intensity)
  );
  // 11-bit compares so a key near the right edge cannot wrap past column 1023
  always_comb begin
    hx    = {1'b0, bus.h_cnt};
    vy    = {1'b0, bus.v_cnt};
    px    = {1'b0, cur_pos};
    top   = {1'b0, KEY_TOP};
    w     = {1'b0, cur_black ? BLACK_W : WHITE_W};
    ht    = {1'b0, cur_black ? BLACK_H : WHITE_H};
    hit_c = bus.valid && active && vy >= top && vy < top + ht && hx >= px && hx < px + w;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.hit         <= 1'b0;
      bus.rgb         <= '0;
      bus.pixel_valid <= 1'b0;
    end else begin
      bus.hit         <= hit_c;
      bus.rgb         <= hit_c ? shade(cur_black, intensity) : 12'h000;
      bus.pixel_valid <= bus.valid;
    end
endmodule

// File: doc/key_highlight.md
# key_highlight

Overlay renderer downstream of the pitch-to-keyboard-position mapper. It takes the mapped key x-position, the black-key flag and a note-on qualifier, latches them once per VGA frame, and paints a highlight rectangle over the pressed key on the on-screen keyboard band. After release, the highlight fades out over a programmable number of frames. Its output feeds the final pixel mixer, which gives a hit priority over the base keyboard image.

## Interface
- `KEY_TOP`, 360: first row of the keyboard band.
- `WHITE_W`, 23: highlight width in pixels for white keys.
- `BLACK_W`, 12: highlight width in pixels for black keys.
- `WHITE_H`, 120: highlight height in rows for white keys.
- `BLACK_H`, 80: highlight height in rows for black keys.
- `HOLD_FRAMES`, 15: fade length in frames; legal range 1..15.
- `clk` in 1: pixel clock.
- `rst` in 1: reset, asynchronous, active-high.
- `note_on` in 1: a note is currently sounding.
- `position` in 10: key left edge from the mapper; the value 640 means no key.
- `black` in 1: key is black.
- `frame_start` in 1: one-cycle pulse, asserted once per frame during blanking.
- `h_cnt` in 10: current pixel column.
- `v_cnt` in 10: current pixel row.
- `valid` in 1: pixel is inside the active area.
- `hit` out 1: the highlight covers this pixel.
- `rgb` out 12: highlight colour as {R,G,B}, 4 bits per channel.
- `pixel_valid` out 1: `valid` delayed to align with `hit` and `rgb`.

## Operation
- Effective press: `press = note_on && position != 640`.
- Frame state (`cur_pos[9:0]`, `cur_black`, `hold_cnt[3:0]`, FSM) updates only on cycles where `frame_start` is 1. On all other cycles it holds.
- FSM states are IDLE, ACTIVE and FADE.
  - IDLE: on `press`, go to ACTIVE and latch `position` and `black`.
  - ACTIVE: on `press`, stay in ACTIVE and re-latch `position` and `black`. A key change switches the highlight instantly; the old key gets no fade. On `!press`, go to FADE with `hold_cnt = HOLD_FRAMES`.
  - FADE: on `press`, go to ACTIVE, latch the inputs and clear `hold_cnt` to 0. On `!press` with `hold_cnt > 1`, decrement `hold_cnt`. On `!press` with `hold_cnt == 1`, go to IDLE with `hold_cnt = 0`.
- Intensity `I[3:0]`: 15 in ACTIVE, `hold_cnt` in FADE, 0 in IDLE.
- Hit condition: `valid` AND state != IDLE AND `KEY_TOP <= v_cnt < KEY_TOP+H` AND `cur_pos <= h_cnt < cur_pos+W`.
  - `W` and `H` are the black or white values, selected by `cur_black`.
  - All compares are evaluated in 11-bit unsigned arithmetic, so 618+23 = 641 does not wrap.
- Colour on a hit:
  - white key: `{4'h0, I, 4'h0}` (green).
  - black key: `{I, 4'h0, 4'h0}` (red).
- When there is no hit, `hit` = 0 and `rgb` = 12'h000.

## Timing
- Reset values: state IDLE, `hold_cnt` 0, `cur_pos` 0, `cur_black` 0, `hit` 0, `rgb` 0, `pixel_valid` 0.
- `rst` asserted mid-frame forces these values immediately. The first highlight after release can appear no earlier than the frame following the first `frame_start`.
- Pixel-path latency is 1 cycle: `hit`, `rgb` and `pixel_valid` are registered from `h_cnt`, `v_cnt` and `valid` of the previous cycle.
- Frame-state latency: inputs sampled at `frame_start` affect pixels starting the cycle after that pulse. The image therefore never tears within a frame.
- Simultaneous events:
  - If `frame_start` and `valid` are both 1 in the same cycle (protocol violation), the pixel uses the pre-update state.
  - `note_on` changes between `frame_start` pulses are ignored.
- A fade is visible for exactly `HOLD_FRAMES` frames, with intensities `HOLD_FRAMES` down to 1, and then goes dark.

## Structure
- A shared package `keyboard_pkg` holds:
  - geometry constants: `KEY_TOP`, widths, heights, and `NO_KEY_POS` = 640.
  - the 3-state FSM enum.
  - the colour constants.
  - The mapper and the mixer use the same package.
- One natural sub-module, `highlight_fade_fsm`. It contains the FSM, `hold_cnt` and the latches, and outputs `active`, `cur_pos`, `cur_black` and `I`.
- The top level contains the compare/colour pixel stage and its output registers.

## Test plan
- Press `position` = 116 (white), then one `frame_start`; scan row 400 -> `hit` = 1 exactly for h 116..138, with `rgb` = 12'h0F0, one cycle after the matching `h_cnt`.
- Press `position` = 110 (black) -> at row 420, hit for h 110..121 with `rgb` = 12'hF00; at row 450, no hit.
- Release after ACTIVE with `HOLD_FRAMES` = 15 -> green nibble reads 15,14,…,1 over the next 15 frames, then 0 with state IDLE. Re-press during the fade at `hold_cnt` = 7 -> next frame shows 15.
- `position` = 618, white -> hit for h 618..639 with no wrap (no hit at h 0..17). Then `position` = 640 with `note_on` = 1 -> treated as release, fade starts.
- Change `note_on` and `position` mid-frame -> no output change until after the next `frame_start`.
- Assert `rst` during ACTIVE mid-scan -> `hit` and `rgb` are 0 asynchronously, and state is IDLE.
